// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU select codes common to the control unit, the alu
// and the pipelined datapath, plus the EX-stage control bundle.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_NOR    = 4'd5,
    ALU_SLT    = 4'd6,
    ALU_SLTU   = 4'd7,
    ALU_SLL    = 4'd8,
    ALU_SRL    = 4'd9,
    ALU_SRA    = 4'd10,
    ALU_PASS_B = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic    rf_write;
    logic    mem_write;
    logic    mem_sel;
    alu_op_e alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '{
    rf_write:  1'b0,
    mem_write: 1'b0,
    mem_sel:   1'b0,
    alu_op:    ALU_ADD
  };

endpackage

// File: rtl/param_register_file.sv
// Parametrised register file: two asynchronous read ports, one synchronous write
// port, synchronous clear, and a dedicated tap on a single register.
module param_register_file #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int OUT_REG    = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0]     rd_data0,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     tap_data
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: this array is small and architecturally visible, so it is cleared on
  // reset entry by entry; the much larger data memory is deliberately left
  // unreset so it can map onto RAM.
  // NOTE: state is only ever updated with non-blocking assignments so every
  // reader samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];
  assign tap_data = regs[REG_ADDR_W'(OUT_REG)];

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage (EX, WB) datapath: register file, operand mux, ALU, synchronous data
// memory and writeback, with EX/WB forwarding and a one-cycle load-use stall.
module pipelined_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_ADDR_W = 5,
  parameter int OUT_REG    = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  rf_write,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     imm_data,
  input  logic [3:0]            alu_sel,
  input  logic                  imm_sel,
  input  logic                  mem_write,
  input  logic                  mem_sel,
  output logic                  out_valid,
  output logic                  zero_flag,
  output logic                  pos_flag,
  output logic [DATA_W-1:0]     out_reg_data
);

  localparam int MEM_DEPTH = 1 << MEM_ADDR_W;

  // EX stage
  logic                  ex_valid;
  ex_ctrl_t              ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0]     ex_in0;
  logic [DATA_W-1:0]     ex_in1;
  logic [DATA_W-1:0]     alu_out;
  logic [MEM_ADDR_W-1:0] mem_addr;

  // WB stage
  logic                  wb_valid;
  logic                  wb_rf_write;
  logic                  wb_mem_sel;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_alu;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     wb_result;

  // Issue
  logic [DATA_W-1:0]     rf_rs;
  logic [DATA_W-1:0]     rf_rt;
  logic [DATA_W-1:0]     fwd_rs;
  logic [DATA_W-1:0]     fwd_rt;
  logic                  ex_fwd_en;
  logic                  wb_fwd_en;
  logic                  load_use;
  logic                  accept;

  logic [DATA_W-1:0]     mem [MEM_DEPTH];

  param_register_file #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .OUT_REG   (OUT_REG)
  ) u_rf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wb_valid & wb_rf_write),
    .wr_addr (wb_rd),
    .wr_data (wb_result),
    .rd_addr0(rs_addr),
    .rd_addr1(rt_addr),
    .rd_data0(rf_rs),
    .rd_data1(rf_rt),
    .tap_data(out_reg_data)
  );

  function automatic logic [DATA_W-1:0] pick_operand(
    input logic              ex_hit,
    input logic              wb_hit,
    input logic [DATA_W-1:0] ex_val,
    input logic [DATA_W-1:0] wb_val,
    input logic [DATA_W-1:0] rf_val
  );
    if (ex_hit)      return ex_val;
    else if (wb_hit) return wb_val;
    else             return rf_val;
  endfunction

  // A load in EX has no data yet, so it never forwards; load_use stalls instead.
  assign ex_fwd_en = ex_valid & ex_ctrl.rf_write & ~ex_ctrl.mem_sel;
  assign wb_fwd_en = wb_valid & wb_rf_write;

  assign fwd_rs = pick_operand(ex_fwd_en && (ex_rd == rs_addr),
                               wb_fwd_en && (wb_rd == rs_addr),
                               alu_out, wb_result, rf_rs);
  assign fwd_rt = pick_operand(ex_fwd_en && (ex_rd == rt_addr),
                               wb_fwd_en && (wb_rd == rt_addr),
                               alu_out, wb_result, rf_rt);

  assign load_use = in_valid & ex_valid & ex_ctrl.mem_sel &
                    ((ex_rd == rs_addr) | (~imm_sel & (ex_rd == rt_addr)));
  assign in_ready = ~reset & ~load_use;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= EX_CTRL_NOP;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_ctrl <= '{rf_write:  rf_write,
                     mem_write: mem_write,
                     mem_sel:   mem_sel,
                     alu_op:    alu_op_e'(alu_sel)};
      end
    end
  end

  // Operand payload is qualified by ex_valid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      ex_rd  <= rd_addr;
      ex_in0 <= fwd_rs;
      ex_in1 <= imm_sel ? imm_data : fwd_rt;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    alu_out = '0;
    case (ex_ctrl.alu_op)
      ALU_ADD:    alu_out = ex_in0 + ex_in1;
      ALU_SUB:    alu_out = ex_in0 - ex_in1;
      ALU_AND:    alu_out = ex_in0 & ex_in1;
      ALU_OR:     alu_out = ex_in0 | ex_in1;
      ALU_XOR:    alu_out = ex_in0 ^ ex_in1;
      ALU_NOR:    alu_out = ~(ex_in0 | ex_in1);
      ALU_SLT:    alu_out = DATA_W'($signed(ex_in0) < $signed(ex_in1));
      ALU_SLTU:   alu_out = DATA_W'(ex_in0 < ex_in1);
      ALU_SLL:    alu_out = ex_in0 << ex_in1;
      ALU_SRL:    alu_out = ex_in0 >> ex_in1;
      ALU_SRA:    alu_out = $signed(ex_in0) >>> ex_in1;
      ALU_PASS_B: alu_out = ex_in1;
      default:    alu_out = '0;
    endcase
  end

  assign mem_addr = alu_out[MEM_ADDR_W-1:0];

  // Write and read share the end-of-EX edge; a store in EX while reset is high is dropped.
  always_ff @(posedge clock) begin
    if (!reset && ex_valid && ex_ctrl.mem_write) begin
      mem[mem_addr] <= ex_in0;
    end
    mem_rdata <= mem[mem_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_rf_write <= 1'b0;
      wb_mem_sel  <= 1'b0;
      zero_flag   <= 1'b0;
      pos_flag    <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rf_write <= ex_ctrl.rf_write;
        wb_mem_sel  <= ex_ctrl.mem_sel;
        zero_flag   <= (alu_out == '0);
        pos_flag    <= ~alu_out[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ex_valid) begin
      wb_rd  <= ex_rd;
      wb_alu <= alu_out;
    end
  end

  assign wb_result = wb_mem_sel ? mem_rdata : wb_alu;
  assign out_valid = wb_valid & ~reset;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Bench for pipelined_datapath: directed scenarios plus random instruction
// streams checked against a sequential instruction-level reference model.
module tb_pipelined_datapath;
  import cpu_pkg::*;

  localparam int DW        = 16;
  localparam int MEM_WORDS = 32;
  localparam int OUT_IDX   = 7;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 16-bit instance
  logic          reset, in_valid, in_ready, rf_write, imm_sel, mem_write, mem_sel;
  logic [2:0]    rs_addr, rt_addr, rd_addr;
  logic [DW-1:0] imm_data;
  logic [3:0]    alu_sel;
  logic          out_valid, zero_flag, pos_flag;
  logic [DW-1:0] out_reg_data;

  pipelined_datapath u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel),
    .mem_write(mem_write), .mem_sel(mem_sel), .out_valid(out_valid),
    .zero_flag(zero_flag), .pos_flag(pos_flag), .out_reg_data(out_reg_data)
  );

  // 32-bit, 16-register instance
  logic        reset_w, in_valid_w, in_ready_w, rf_write_w, imm_sel_w, mem_write_w, mem_sel_w;
  logic [3:0]  rs_w, rt_w, rd_w, alu_w;
  logic [31:0] imm_w;
  logic        out_valid_w, zero_w, pos_w;
  logic [31:0] out_reg_w;

  pipelined_datapath #(.DATA_W(32), .REG_ADDR_W(4), .MEM_ADDR_W(5), .OUT_REG(15)) u_dut32 (
    .clock(clock), .reset(reset_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .rf_write(rf_write_w), .rs_addr(rs_w), .rt_addr(rt_w), .rd_addr(rd_w),
    .imm_data(imm_w), .alu_sel(alu_w), .imm_sel(imm_sel_w),
    .mem_write(mem_write_w), .mem_sel(mem_sel_w), .out_valid(out_valid_w),
    .zero_flag(zero_w), .pos_flag(pos_w), .out_reg_data(out_reg_w)
  );

  typedef struct packed {
    logic [3:0]    alu;
    logic [2:0]    rs, rt, rd;
    logic [DW-1:0] imm;
    logic          imm_sel, rf_write, mem_write, mem_sel;
  } instr_t;

  typedef struct packed {
    logic          zero, pos;
    logic [DW-1:0] r_out;
    logic          is_store;
    logic [4:0]    addr;
    logic [DW-1:0] old;
  } rec_t;

  // Architectural reference state
  logic [DW-1:0] m_reg [8];
  logic [DW-1:0] m_mem [MEM_WORDS];
  rec_t          q[$];

  // Observation bookkeeping
  logic          ex_exp, wb_exp, ex_load, last_acc;
  logic [2:0]    ex_rd;
  logic          exp_zero, exp_pos, pend_v;
  logic [DW-1:0] exp_out, pend_d;
  logic [2:0]    last_rd;
  int            n_vec, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~(a | b);
      4'd6:    r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd7:    r = (a < b) ? 16'd1 : 16'd0;
      4'd8:    r = (b >= 16) ? 16'd0 : a << b;
      4'd9:    r = (b >= 16) ? 16'd0 : a >> b;
      4'd10:   r = (b >= 16) ? {16{a[15]}} : DW'($signed(a) >>> b);
      4'd11:   r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input int rs, input int rt, input int rd,
                                input logic [DW-1:0] imm, input logic isel, input logic rfw,
                                input logic mw, input logic ms);
    instr_t i;
    i.alu = op; i.rs = 3'(rs); i.rt = 3'(rt); i.rd = 3'(rd); i.imm = imm;
    i.imm_sel = isel; i.rf_write = rfw; i.mem_write = mw; i.mem_sel = ms;
    return i;
  endfunction

  // Executes one instruction to completion in program order.
  task automatic exec_model(input instr_t i);
    logic [DW-1:0] a, b, y, res;
    rec_t rec;
    a = m_reg[i.rs];
    b = i.imm_sel ? i.imm : m_reg[i.rt];
    y = alu_ref(i.alu, a, b);
    rec.addr     = 5'(y % MEM_WORDS);
    rec.is_store = i.mem_write;
    rec.old      = m_mem[rec.addr];
    if (i.mem_write) m_mem[rec.addr] = a;
    res = i.mem_sel ? m_mem[rec.addr] : y;
    if (i.rf_write) m_reg[i.rd] = res;
    rec.zero  = (y == 0);
    rec.pos   = !y[DW-1];
    rec.r_out = m_reg[OUT_IDX];
    q.push_back(rec);
  endtask

  // One clock: check in_ready before the edge, update the model on the edge,
  // check retirement outputs on the following falling edge.
  task automatic cycle();
    logic   hit, exp_rdy, acc;
    instr_t cur;
    rec_t   rec;
    #1;
    hit     = ex_load && (ex_rd == rs_addr || (!imm_sel && ex_rd == rt_addr));
    exp_rdy = !reset && !(in_valid && hit);
    check("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    cur = mk(alu_sel, rs_addr, rt_addr, rd_addr, imm_data, imm_sel, rf_write, mem_write, mem_sel);
    @(posedge clock);
    if (reset) begin
      while (q.size() > 0) begin
        rec = q.pop_back();
        if (rec.is_store) m_mem[rec.addr] = rec.old;
      end
      for (int r = 0; r < 8; r++) m_reg[r] = '0;
      ex_exp = 0; wb_exp = 0; ex_load = 0;
      exp_zero = 0; exp_pos = 0; exp_out = '0; pend_v = 0;
      last_acc = 0;
    end else begin
      wb_exp   = ex_exp;
      ex_exp   = acc;
      ex_load  = acc && cur.mem_sel;
      ex_rd    = cur.rd;
      last_acc = acc;
      if (acc) exec_model(cur);
    end
    @(negedge clock);
    if (pend_v) exp_out = pend_d;
    pend_v = 0;
    check("out_valid", out_valid, wb_exp);
    if (wb_exp && q.size() > 0) begin
      rec = q.pop_front();
      exp_zero = rec.zero;
      exp_pos  = rec.pos;
      pend_v   = 1;
      pend_d   = rec.r_out;
    end
    check("zero_flag", zero_flag, exp_zero);
    check("pos_flag", pos_flag, exp_pos);
    check("out_reg_data", out_reg_data, exp_out);
  endtask

  task automatic drive(input instr_t i);
    alu_sel = i.alu; rs_addr = i.rs; rt_addr = i.rt; rd_addr = i.rd; imm_data = i.imm;
    imm_sel = i.imm_sel; rf_write = i.rf_write; mem_write = i.mem_write; mem_sel = i.mem_sel;
  endtask

  task automatic issue(input instr_t i, output int tries);
    drive(i);
    in_valid = 1'b1;
    tries = 0;
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < 4);
    if (!last_acc) check("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    last_rd  = i.rd;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive(mk(4'($urandom_range(0, 11)), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), DW'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom)));
      cycle();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int r;
    i = mk(4'($urandom_range(0, 11)), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), DW'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    if ($urandom_range(0, 9) < 3) i.rs = last_rd;
    if ($urandom_range(0, 9) < 2) i.rt = last_rd;
    r = $urandom_range(0, 99);
    i.mem_sel   = (r < 20);
    i.mem_write = (r >= 20 && r < 35);
    i.rf_write  = ($urandom_range(0, 9) != 0);
    return i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    n_vec = 0; n_err = 0;
    ex_exp = 0; wb_exp = 0; ex_load = 0; ex_rd = '0; last_acc = 0; last_rd = '0;
    exp_zero = 0; exp_pos = 0; exp_out = '0; pend_v = 0; pend_d = '0;
    for (int r = 0; r < 8; r++) m_reg[r] = '0;
    for (int a = 0; a < MEM_WORDS; a++) m_mem[a] = 'x;
    reset = 1'b1; in_valid = 1'b0;
    drive(mk(4'd0, 0, 0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset_w = 1'b1; in_valid_w = 1'b0; rf_write_w = 1'b0; rs_w = '0; rt_w = '0; rd_w = '0;
    alu_w = '0; imm_w = '0; imm_sel_w = 1'b0; mem_write_w = 1'b0; mem_sel_w = 1'b0;

    @(negedge clock);
    do_reset(2);

    // Give every data memory word a known value (store r0=0 to address imm).
    for (int a = 0; a < MEM_WORDS; a++) issue(mk(ALU_ADD, 0, 0, 0, DW'(a), 1, 0, 1, 0), tries);

    // 1: back-to-back dependent adds, no stall
    issue(mk(ALU_ADD, 0, 0, 1, 16'd5, 1, 1, 0, 0), tries);
    issue(mk(ALU_ADD, 1, 0, 7, 16'd3, 1, 1, 0, 0), tries);
    check("t1_no_stall", 32'(tries), 32'd1);
    idle(2);
    check("t1_r7", out_reg_data, 16'd8);

    // 2: store r1 to 4, load r2, dependent add stalls once
    issue(mk(ALU_ADD, 1, 0, 0, 16'hFFFF, 1, 0, 1, 0), tries);
    issue(mk(ALU_ADD, 0, 0, 2, 16'd4, 1, 1, 0, 1), tries);
    issue(mk(ALU_ADD, 2, 2, 3, 16'd0, 0, 1, 0, 0), tries);
    check("t2_stall_cycles", 32'(tries), 32'd2);
    issue(mk(ALU_ADD, 3, 0, 7, 16'd0, 1, 1, 0, 0), tries);
    idle(3);
    check("t2_r7", out_reg_data, 16'd10);

    // 3: flag extremes
    issue(mk(ALU_SUB, 1, 1, 4, 16'd0, 0, 1, 0, 0), tries);
    idle(1);
    check("t3_zero_hi", {out_valid, zero_flag, pos_flag}, 3'b111);
    issue(mk(ALU_ADD, 0, 0, 5, 16'h8000, 1, 1, 0, 0), tries);
    idle(1);
    check("t3_neg", {out_valid, zero_flag, pos_flag}, 3'b100);

    // 4: address 37 wraps to word 5; idle gaps hold flags
    issue(mk(ALU_ADD, 1, 0, 0, 16'd32, 1, 0, 1, 0), tries);
    idle(3);
    issue(mk(ALU_ADD, 0, 0, 7, 16'd5, 1, 1, 0, 1), tries);
    idle(3);
    check("t4_word5", out_reg_data, 16'd5);

    // 5: reset with a store in EX and a load in WB
    issue(mk(ALU_ADD, 1, 0, 0, 16'd4, 1, 0, 1, 0), tries);
    issue(mk(ALU_ADD, 0, 0, 6, 16'h00AB, 1, 1, 0, 0), tries);
    idle(2);
    issue(mk(ALU_ADD, 0, 0, 2, 16'd4, 1, 1, 0, 1), tries);
    issue(mk(ALU_ADD, 6, 0, 0, 16'(16'd9 - 16'h00AB), 1, 0, 1, 0), tries);
    do_reset(2);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_out_reg", out_reg_data, 16'd0);
    issue(mk(ALU_ADD, 0, 0, 7, 16'd9, 1, 1, 0, 1), tries);
    idle(3);
    check("t5_mem9", out_reg_data, 16'd5);

    // Random instruction stream with occasional gaps and resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if (n % 100 == 99) do_reset(1);
      issue(rand_instr(), tries);
    end
    idle(3);

    // 6: 32-bit, 16-register wraparound to zero
    reset_w = 1'b0;
    in_valid_w = 1'b1; alu_w = ALU_ADD; rs_w = 4'd0; rd_w = 4'd15;
    imm_w = 32'hFFFF_FFFF; imm_sel_w = 1'b1; rf_write_w = 1'b1;
    #1 check("t6_ready_a", in_ready_w, 1'b1);
    @(negedge clock);
    rs_w = 4'd15; imm_w = 32'd1;
    #1 check("t6_ready_b", in_ready_w, 1'b1);
    @(negedge clock);
    in_valid_w = 1'b0;
    check("t6_wb_a", {out_valid_w, zero_w, pos_w}, 3'b100);
    @(negedge clock);
    check("t6_wb_b", {out_valid_w, zero_w, pos_w}, 3'b111);
    check("t6_r15_a", out_reg_w, 32'hFFFF_FFFF);
    @(negedge clock);
    check("t6_r15_b", out_reg_w, 32'd0);
    check("t6_idle", {out_valid_w, zero_w}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
